pipe_reg_chain: RTL and testbench
=================================

# pipe_reg_chain

Parametrised elastic pipeline register: a chain of `DEPTH` valid-tagged register stages of `WIDTH` bits each. Each stage uses flow control, so backpressure stalls data in place and empty slots (bubbles) are filled. A synchronous flush clears the chain. It is the successor to the single resettable, enable-gated flop. It is used between datapath stages of the processor wherever stall and squash must be handled without ad-hoc enable/reset wiring.

## Interface
- `WIDTH`, default 64: data width of each stage.
- `DEPTH`, default 3, legal range ≥1: number of register stages.
- `RESET_VAL`, default 0: value loaded into every data register on reset or flush.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `flush` in 1: synchronous squash of all stages.
- `in_valid` in 1: upstream offers `d`.
- `in_ready` out 1: chain accepts `d` this cycle.
- `d` in `WIDTH`: input data.
- `out_valid` out 1: `q` holds a valid word.
- `out_ready` in 1: downstream accepts `q` this cycle.
- `q` out `WIDTH`: data of the last stage.
- `occupancy` out `$clog2(DEPTH+1)`: number of valid stages.

## Operation
- **Per-stage state.** Stage i (0 = input side, DEPTH-1 = output side) holds `data[i]` and `v[i]`.
- **Ready chain (combinational).**
  - `rdy[DEPTH] = out_ready`.
  - `rdy[i] = !v[i] || rdy[i+1]`.
  - `in_ready = rdy[0] && !flush && !reset`.
- **Transfers.**
  - Input transfer when `in_valid && in_ready`.
  - Output transfer when `out_valid && out_ready`.
  - `out_valid = v[DEPTH-1] && !flush && !reset`.
  - `q = data[DEPTH-1]`.
- **Stage update when `rdy[i]`.**
  - `v[i] <= valid of the upstream source` (stage i-1, or the input for i=0).
  - `data[i]` loads upstream data only when the upstream is valid; otherwise it holds its old value.
- **Stall.** When `!rdy[i]`, stage i holds both data and valid unchanged. This is the enable behaviour.
- **Reset and flush.**
  - `reset` or `flush` clears every `v[i]` to 0 and loads every `data[i]` with `RESET_VAL`.
  - `reset` has priority over `flush`; both have identical effect.
  - During a flush cycle, no input or output transfer occurs, even if `out_ready=1`.
- **Occupancy.** `occupancy` is a registered count equal to the popcount of `v`. Update each cycle:
  - +1 on input transfer.
  - −1 on output transfer.
  - Unchanged when both occur.
  - 0 on reset or flush.
- **Ordering.** Words leave in acceptance order. No word is duplicated or dropped, except on flush or reset.

## Timing
- **Reset values.** `out_valid=0`, `q=RESET_VAL`, `occupancy=0`, `in_ready=0` while `reset` is high. `in_ready=1` on the first cycle after reset deasserts.
- **Latency.** A word accepted at edge N appears on `q` with `out_valid=1` after edge N+DEPTH-1, i.e. visible in cycle N+DEPTH when the chain is empty and `out_ready=1`.
- **Throughput.** One word per cycle with `out_ready` held high.
- **Full.** When `occupancy==DEPTH` and `out_ready=0`, `in_ready=0`. If `out_ready=1` while full, `in_ready=1` in the same cycle, giving simultaneous in/out.
- **Combinational path.** `out_ready` → `in_ready` is combinational, through DEPTH levels. There is no combinational path from `in_valid` to `out_valid`.
- **Flush mid-stall.**
  - Takes effect at the next edge regardless of `out_ready`.
  - The word offered during the flush cycle is not accepted.
  - The upstream must re-present it.

## Structure
- **Package `pipe_pkg`.** A localparam helper for the occupancy width, `OCC_W(DEPTH)`. No typedefs; data is a plain `logic [WIDTH-1:0]`.
- **Sub-module `pipe_stage`.** One valid-tagged stage with ports `clk`, `reset`, `flush`, `up_valid`, `up_data`, `dn_ready`, `rdy`, `v`, `data`, parameters `WIDTH` and `RESET_VAL`. It is instantiated DEPTH times in a generate loop.
- **Top level.** Contains only the ready chain, the occupancy counter and the output gating.

## Test plan
All scenarios use WIDTH=64, DEPTH=3, RESET_VAL=0 unless stated.
- **Reset.** Hold `reset=1` for 5 cycles with `in_valid=1`, `d=64'h6523`, `out_ready=1`. Required: `q=0`, `out_valid=0`, `occupancy=0` and `in_ready=0` throughout; no word emerges later.
- **Streaming.** Present `64'h1`, `64'habcde`, `64'h5555` on consecutive cycles with `out_ready=1`. Required: `in_ready` stays 1 and the words appear on `q` with `out_valid=1` 3 cycles after each acceptance, in order.
- **Backpressure.** With `out_ready=0`, offer `64'h8956`, `64'hfabd`, `64'hbbdd`, `64'h8888` back-to-back. Required:
  - The first three are accepted and `occupancy=3`.
  - `in_ready=0` for `64'h8888`.
  - `q` stays `64'h8956`.
  - After `out_ready=1`, the outputs are `8956`, `fabd`, `bbdd`, `8888`, with none lost or duplicated.
- **Flush.** With `occupancy=2`, assert `flush` for one cycle while offering `64'h223432` with `out_ready=1`. Required: in the flush cycle `out_valid=0` and `in_ready=0`; next cycle `occupancy=0`, `out_valid=0`, `q=0`; `64'h223432` never emerges.
- **Bubbles.** Offer `in_valid` on alternate cycles and toggle `out_ready` with a pseudo-random pattern. Required: the output sequence equals the input sequence, and `occupancy` always equals the number of accepted words minus the number of emitted words.
- **DEPTH=1.** Instance with `DEPTH=1`, `RESET_VAL=64'hffff`. Required: `q=64'hffff` after reset, 1-cycle latency, and a full-throughput stream with `out_ready=1`.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared helpers for the elastic pipeline register chain
package pipe_pkg;
  function automatic int OCC_W(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/pipe_stage.sv
// pipe_stage: one valid-tagged register stage that stalls in place and fills bubbles
module pipe_stage #(
  parameter int WIDTH = 64,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             dn_ready,
  output logic             rdy,
  output logic             v,
  output logic [WIDTH-1:0] data
);
  assign rdy = !v || dn_ready;
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      v    <= 1'b0;
      data <= RESET_VAL;
    end else if (rdy) begin
      v <= up_valid;
      if (up_valid) data <= up_data;
    end
  end
endmodule

// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: DEPTH-stage elastic pipeline register with backpressure, bubble fill and flush
module pipe_reg_chain
  import pipe_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          d,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          q,
  output logic [OCC_W(DEPTH)-1:0]   occupancy
);
  localparam int OW = OCC_W(DEPTH);
  logic [DEPTH:0]            rdy;
  logic [DEPTH:0]            vc;
  logic [DEPTH:0][WIDTH-1:0] dc;
  logic                      in_xfer;
  logic                      out_xfer;
  // index 0 is the upstream port, index i+1 is stage i
  assign rdy[DEPTH] = out_ready;
  assign vc[0]      = in_valid;
  assign dc[0]      = d;
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    pipe_stage #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_stage (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .up_valid (vc[i]),
      .up_data  (dc[i]),
      .dn_ready (rdy[i+1]),
      .rdy      (rdy[i]),
      .v        (vc[i+1]),
      .data     (dc[i+1])
    );
  end
  assign in_ready  = rdy[0] && !flush && !reset;
  assign out_valid = vc[DEPTH] && !flush && !reset;
  assign q         = dc[DEPTH];
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  always_ff @(posedge clk) begin
    if (reset || flush) occupancy <= '0;
    else occupancy <= occupancy + OW'(in_xfer) - OW'(out_xfer);
  end
endmodule

// File: tb/tb_pipe_reg_chain.sv
// tb_pipe_reg_chain: directed self-checking bench for the DEPTH=3 chain and a DEPTH=1 instance
module tb_pipe_reg_chain;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [63:0] d = '0;
  logic        in_ready, out_valid, in_ready1, out_valid1;
  logic [63:0] q, q1;
  logic [1:0]  occupancy;
  logic [0:0]  occupancy1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_reg_chain #(.WIDTH(64), .DEPTH(3), .RESET_VAL(64'h0)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .d(d), .out_valid(out_valid), .out_ready(out_ready), .q(q), .occupancy(occupancy)
  );

  pipe_reg_chain #(.WIDTH(64), .DEPTH(1), .RESET_VAL(64'hffff)) dut1 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .d(d), .out_valid(out_valid1), .out_ready(out_ready), .q(q1), .occupancy(occupancy1)
  );

  task automatic test_reset;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b1; d = 64'h6523; out_ready = 1'b1;
    @(posedge clk);
    repeat (5) begin
      @(negedge clk); #1;
      checks++;
      if (q !== 64'h0 || out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: q=%h out_valid=%b occ=%0d in_ready=%b, required 0 0 0 0", q, out_valid, occupancy, in_ready);
      end
    end
    @(negedge clk); reset = 1'b0; in_valid = 1'b0; #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_in_ready: got %b, required 1", in_ready);
    end
    repeat (4) begin
      @(negedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
        errors++;
        $display("FAIL reset_no_word: out_valid=%b occ=%0d, required 0 0", out_valid, occupancy);
      end
    end
  endtask

  task automatic test_streaming;
    logic [63:0] w [3];
    logic [1:0]  oe [7];
    w[0] = 64'h1; w[1] = 64'habcde; w[2] = 64'h5555;
    oe[0] = 2'd0; oe[1] = 2'd1; oe[2] = 2'd2; oe[3] = 2'd3; oe[4] = 2'd2; oe[5] = 2'd1; oe[6] = 2'd0;
    for (int t = 0; t < 7; t++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid = (t < 3);
      if (t < 3) d = w[t];
      #1;
      if (t < 3) begin
        checks++;
        if (in_ready !== 1'b1) begin
          errors++;
          $display("FAIL stream_in_ready t=%0d: got %b, required 1", t, in_ready);
        end
      end
      checks++;
      if (out_valid !== (t >= 3 && t <= 5)) begin
        errors++;
        $display("FAIL stream_out_valid t=%0d: got %b, required %b", t, out_valid, (t >= 3 && t <= 5));
      end
      if (t >= 3 && t <= 5) begin
        checks++;
        if (q !== w[t-3]) begin
          errors++;
          $display("FAIL stream_q t=%0d: got %h, required %h", t, q, w[t-3]);
        end
      end
      checks++;
      if (occupancy !== oe[t]) begin
        errors++;
        $display("FAIL stream_occ t=%0d: got %0d, required %0d", t, occupancy, oe[t]);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure;
    logic [63:0] w [4];
    logic [63:0] got [4];
    int n = 0;
    bit sent = 1'b0;
    w[0] = 64'h8956; w[1] = 64'hfabd; w[2] = 64'hbbdd; w[3] = 64'h8888;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk); out_ready = 1'b0; in_valid = 1'b1; d = w[t]; #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL bp_accept t=%0d: in_ready=%b, required 1", t, in_ready);
      end
    end
    repeat (2) begin
      @(negedge clk); d = w[3]; #1;
      checks++;
      if (in_ready !== 1'b0 || occupancy !== 2'd3 || q !== 64'h8956 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_full: in_ready=%b occ=%0d q=%h out_valid=%b, required 0 3 8956 1", in_ready, occupancy, q, out_valid);
      end
    end
    for (int t = 0; t < 10; t++) begin
      @(negedge clk); out_ready = 1'b1; in_valid = !sent; d = w[3]; #1;
      if (t == 0) begin
        checks++;
        if (in_ready !== 1'b1) begin
          errors++;
          $display("FAIL bp_full_passthrough_ready: got %b, required 1", in_ready);
        end
      end
      if (out_valid) begin
        if (n < 4) got[n] = q;
        n++;
      end
      if (in_valid && in_ready) sent = 1'b1;
    end
    in_valid = 1'b0;
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL bp_count: got %0d words, required 4", n);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= n || got[i] !== w[i]) begin
        errors++;
        $display("FAIL bp_order[%0d]: got %h, required %h", i, (i < n) ? got[i] : 64'hx, w[i]);
      end
    end
  endtask

  task automatic test_flush;
    @(negedge clk); out_ready = 1'b0; in_valid = 1'b1; d = 64'haa;
    @(negedge clk); d = 64'hbb;
    @(negedge clk); in_valid = 1'b0; #1;
    checks++;
    if (occupancy !== 2'd2) begin
      errors++;
      $display("FAIL flush_pre_occ: got %0d, required 2", occupancy);
    end
    @(negedge clk); flush = 1'b1; in_valid = 1'b1; d = 64'h223432; out_ready = 1'b1; #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_cycle: out_valid=%b in_ready=%b, required 0 0", out_valid, in_ready);
    end
    @(negedge clk); flush = 1'b0; in_valid = 1'b0; #1;
    checks++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0 || q !== 64'h0) begin
      errors++;
      $display("FAIL flush_after: occ=%0d out_valid=%b q=%h, required 0 0 0", occupancy, out_valid, q);
    end
    repeat (5) begin
      @(negedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_no_emerge: out_valid=%b q=%h, required 0", out_valid, q);
      end
    end
  endtask

  task automatic test_bubbles;
    logic [63:0] sb [$];
    logic [15:0] pat = 16'b1011_0010_1110_0101;
    logic [63:0] nxt = 64'h100;
    int acc = 0;
    int emi = 0;
    int offered = 0;
    bit pend = 1'b0;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (!pend && t % 2 == 0 && t < 40) begin
        pend = 1'b1;
        nxt = nxt + 64'h3;
        offered++;
      end
      in_valid = pend; d = nxt;
      out_ready = (t >= 40) ? 1'b1 : pat[t % 16];
      #1;
      checks++;
      if (occupancy !== 2'(acc - emi)) begin
        errors++;
        $display("FAIL bubble_occ t=%0d: got %0d, required %0d", t, occupancy, acc - emi);
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL bubble_extra t=%0d: got %h, required no word", t, q);
        end else begin
          if (q !== sb[0]) begin
            errors++;
            $display("FAIL bubble_order t=%0d: got %h, required %h", t, q, sb[0]);
          end
          void'(sb.pop_front());
        end
        emi++;
      end
      if (in_valid && in_ready) begin
        sb.push_back(d);
        acc++;
        pend = 1'b0;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (pend || sb.size() != 0 || acc != offered || emi != offered) begin
      errors++;
      $display("FAIL bubble_drain: pending=%b left=%0d accepted=%0d emitted=%0d, required 0 0 %0d %0d", pend, sb.size(), acc, emi, offered, offered);
    end
  endtask

  task automatic test_depth1;
    logic [63:0] w [4];
    w[0] = 64'h11; w[1] = 64'h22; w[2] = 64'h33; w[3] = 64'h44;
    @(negedge clk); reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (q1 !== 64'hffff || out_valid1 !== 1'b0 || occupancy1 !== 1'b0 || in_ready1 !== 1'b0) begin
      errors++;
      $display("FAIL d1_reset: q=%h out_valid=%b occ=%0d in_ready=%b, required ffff 0 0 0", q1, out_valid1, occupancy1, in_ready1);
    end
    for (int t = 0; t < 6; t++) begin
      @(negedge clk); reset = 1'b0; in_valid = (t < 4);
      if (t < 4) d = w[t];
      #1;
      if (t < 4) begin
        checks++;
        if (in_ready1 !== 1'b1) begin
          errors++;
          $display("FAIL d1_in_ready t=%0d: got %b, required 1", t, in_ready1);
        end
      end
      checks++;
      if (out_valid1 !== (t >= 1 && t <= 4)) begin
        errors++;
        $display("FAIL d1_out_valid t=%0d: got %b, required %b", t, out_valid1, (t >= 1 && t <= 4));
      end
      if (t >= 1 && t <= 4) begin
        checks++;
        if (q1 !== w[t-1]) begin
          errors++;
          $display("FAIL d1_q t=%0d: got %h, required %h", t, q1, w[t-1]);
        end
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_bubbles();
    test_depth1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
